// File: rtl/kitchen_hazard_controller_if.sv
// Sensor, acknowledge and actuator bundle for the kitchen hazard controller.
// The master drives the raw sensors and the acknowledge; the slave drives the actuators.
interface kitchen_hazard_controller_if #(
  parameter int ZONES = 2
);
  logic [ZONES-1:0] stove_on;
  logic [ZONES-1:0] fire_det;
  logic [ZONES-1:0] smoke_det;
  logic             alarm_ack;
  logic [ZONES-1:0] sprinkler;
  logic [ZONES-1:0] vent;
  logic             alarm;

  modport master (
    output stove_on, fire_det, smoke_det, alarm_ack,
    input  sprinkler, vent, alarm
  );

  modport slave (
    input  stove_on, fire_det, smoke_det, alarm_ack,
    output sprinkler, vent, alarm
  );
endinterface

// File: rtl/kitchen_hazard_controller.sv
// Multi-zone kitchen fire/smoke controller: sync + debounce per zone, then a
// per-zone FSM driving sprinkler and ventilation, with a shared alarm.
//
//   state          | meaning
//   ST_IDLE        | no hazard, actuators off
//   ST_VENT_ACTIVE | smoke with stove on, venting, escalation timer running
//   ST_VENT_HOLD   | hazard gone, venting until hold timer expires
//   ST_SPRINKLE    | sprinkler latched until acknowledged with sensors clear
module kitchen_hazard_controller #(
  parameter int ZONES     = 2,
  parameter int DEBOUNCE  = 4,
  parameter int SMOKE_ESC = 1000,
  parameter int VENT_HOLD = 500
) (
  input logic                        clk,
  input logic                        rst_n,
  kitchen_hazard_controller_if.slave bus
);

  localparam int DBW  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int CMAX = (SMOKE_ESC > VENT_HOLD) ? SMOKE_ESC : VENT_HOLD;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [DBW-1:0] DB_TC   = DBW'(DEBOUNCE - 1);
  localparam logic [CW-1:0]  ESC_TC  = CW'(SMOKE_ESC - 1);
  localparam logic [CW-1:0]  HOLD_TC = CW'(VENT_HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_VENT_ACTIVE = 2'd1,
    ST_VENT_HOLD   = 2'd2,
    ST_SPRINKLE    = 2'd3
  } state_t;

  logic [ZONES-1:0] r_fire_s1, r_fire_s2;
  logic [ZONES-1:0] r_smoke_s1, r_smoke_s2;
  logic [ZONES-1:0] r_stove_s1, r_stove_s2;
  logic [ZONES-1:0] r_fire_db, r_smoke_db;
  logic [DBW-1:0]   r_fire_cnt  [ZONES];
  logic [DBW-1:0]   r_smoke_cnt [ZONES];
  state_t           r_state     [ZONES];
  logic [CW-1:0]    r_cnt       [ZONES];
  logic             r_alarm;

  logic [ZONES-1:0] w_hz;
  logic [ZONES-1:0] w_vent_req;
  logic [ZONES-1:0] w_sprinkler;
  logic [ZONES-1:0] w_vent;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fire_s1  <= '0;
      r_fire_s2  <= '0;
      r_smoke_s1 <= '0;
      r_smoke_s2 <= '0;
      r_stove_s1 <= '0;
      r_stove_s2 <= '0;
    end else begin
      r_fire_s1  <= bus.fire_det;
      r_fire_s2  <= r_fire_s1;
      r_smoke_s1 <= bus.smoke_det;
      r_smoke_s2 <= r_smoke_s1;
      r_stove_s1 <= bus.stove_on;
      r_stove_s2 <= r_stove_s1;
    end
  end

  // A debounced level only follows after DEBOUNCE consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fire_db  <= '0;
      r_smoke_db <= '0;
      for (int i = 0; i < ZONES; i++) begin
        r_fire_cnt[i]  <= '0;
        r_smoke_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ZONES; i++) begin
        if (r_fire_s2[i] == r_fire_db[i]) begin
          r_fire_cnt[i] <= '0;
        end else if (r_fire_cnt[i] == DB_TC) begin
          r_fire_db[i]  <= r_fire_s2[i];
          r_fire_cnt[i] <= '0;
        end else begin
          r_fire_cnt[i] <= r_fire_cnt[i] + DBW'(1);
        end

        if (r_smoke_s2[i] == r_smoke_db[i]) begin
          r_smoke_cnt[i] <= '0;
        end else if (r_smoke_cnt[i] == DB_TC) begin
          r_smoke_db[i]  <= r_smoke_s2[i];
          r_smoke_cnt[i] <= '0;
        end else begin
          r_smoke_cnt[i] <= r_smoke_cnt[i] + DBW'(1);
        end
      end
    end
  end

  assign w_hz       = r_fire_db | (r_smoke_db & ~r_stove_s2);
  assign w_vent_req = r_smoke_db & r_stove_s2;

  // One counter per zone serves as escalation timer or hold timer depending on state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ZONES; i++) begin
        r_state[i] <= ST_IDLE;
        r_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < ZONES; i++) begin
        case (r_state[i])
          ST_IDLE: begin
            if (w_hz[i]) begin
              r_state[i] <= ST_SPRINKLE;
            end else if (w_vent_req[i]) begin
              r_state[i] <= ST_VENT_ACTIVE;
              r_cnt[i]   <= '0;
            end
          end
          ST_VENT_ACTIVE: begin
            if (w_hz[i]) begin
              r_state[i] <= ST_SPRINKLE;
            end else if (r_smoke_db[i] && (r_cnt[i] == ESC_TC)) begin
              r_state[i] <= ST_SPRINKLE;
            end else if (!r_smoke_db[i]) begin
              r_state[i] <= ST_VENT_HOLD;
              r_cnt[i]   <= '0;
            end else if (r_cnt[i] != '1) begin
              r_cnt[i] <= r_cnt[i] + CW'(1);
            end
          end
          ST_VENT_HOLD: begin
            if (w_hz[i]) begin
              r_state[i] <= ST_SPRINKLE;
            end else if (w_vent_req[i]) begin
              r_state[i] <= ST_VENT_ACTIVE;
              r_cnt[i]   <= '0;
            end else if (r_cnt[i] == HOLD_TC) begin
              r_state[i] <= ST_IDLE;
            end else if (r_cnt[i] != '1) begin
              r_cnt[i] <= r_cnt[i] + CW'(1);
            end
          end
          ST_SPRINKLE: begin
            if (bus.alarm_ack && !r_fire_db[i] && !r_smoke_db[i]) begin
              r_state[i] <= ST_VENT_HOLD;
              r_cnt[i]   <= '0;
            end
          end
          default: r_state[i] <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    w_sprinkler = '0;
    w_vent      = '0;
    for (int i = 0; i < ZONES; i++) begin
      w_sprinkler[i] = (r_state[i] == ST_SPRINKLE);
      w_vent[i]      = (r_state[i] != ST_IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alarm <= 1'b0;
    end else begin
      r_alarm <= |w_sprinkler;
    end
  end

  assign bus.sprinkler = w_sprinkler;
  assign bus.vent      = w_vent;
  assign bus.alarm     = r_alarm;

endmodule

// File: tb/tb_kitchen_hazard_controller.sv
// Directed scenarios plus randomized sensor traffic, checked every cycle
// against a behavioural zone model and a set of hand-computed expectations.
module tb_kitchen_hazard_controller;

  localparam int ZONES     = 2;
  localparam int DEBOUNCE  = 4;
  localparam int SMOKE_ESC = 20;
  localparam int VENT_HOLD = 10;

  localparam int M_IDLE = 0;
  localparam int M_VENT = 1;
  localparam int M_HOLD = 2;
  localparam int M_SPR  = 3;

  logic clk;
  logic rst_n;

  kitchen_hazard_controller_if #(.ZONES(ZONES)) bus();

  kitchen_hazard_controller #(
    .ZONES    (ZONES),
    .DEBOUNCE (DEBOUNCE),
    .SMOKE_ESC(SMOKE_ESC),
    .VENT_HOLD(VENT_HOLD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_pulse();
    bus.alarm_ack = 1'b1;
    tick();
    bus.alarm_ack = 1'b0;
  endtask

  task automatic measure_vent(input int z, output int n);
    n = 0;
    while (bus.vent[z] && n < 50) begin
      n++;
      tick();
    end
  endtask

  // Behavioural model: raw -> two-sample delay -> run-length debounce -> zone mode with time-in-state.
  int m_mode [ZONES];
  int m_age  [ZONES];
  bit m_fs1 [ZONES], m_fs2 [ZONES], m_ss1 [ZONES], m_ss2 [ZONES], m_ts1 [ZONES], m_ts2 [ZONES];
  bit m_fdb [ZONES], m_sdb [ZONES];
  int m_frun [ZONES], m_srun [ZONES];
  bit m_alarm;

  always @(posedge clk or negedge rst_n) begin : model
    bit any_spr, f, s, t, hz;
    if (!rst_n) begin
      for (int z = 0; z < ZONES; z++) begin
        m_mode[z] = M_IDLE; m_age[z] = 0;
        m_fs1[z] = 0; m_fs2[z] = 0; m_ss1[z] = 0; m_ss2[z] = 0; m_ts1[z] = 0; m_ts2[z] = 0;
        m_fdb[z] = 0; m_sdb[z] = 0; m_frun[z] = 0; m_srun[z] = 0;
      end
      m_alarm = 0;
    end else begin
      any_spr = 0;
      for (int z = 0; z < ZONES; z++) if (m_mode[z] == M_SPR) any_spr = 1;
      for (int z = 0; z < ZONES; z++) begin
        f  = m_fdb[z];
        s  = m_sdb[z];
        t  = m_ts2[z];
        hz = f | (s & ~t);
        case (m_mode[z])
          M_IDLE: begin
            if (hz) m_mode[z] = M_SPR;
            else if (s && t) begin m_mode[z] = M_VENT; m_age[z] = 0; end
          end
          M_VENT: begin
            if (hz) m_mode[z] = M_SPR;
            else if (!s) begin m_mode[z] = M_HOLD; m_age[z] = 0; end
            else if (m_age[z] + 1 >= SMOKE_ESC) m_mode[z] = M_SPR;
            else m_age[z]++;
          end
          M_HOLD: begin
            if (hz) m_mode[z] = M_SPR;
            else if (s && t) begin m_mode[z] = M_VENT; m_age[z] = 0; end
            else if (m_age[z] + 1 >= VENT_HOLD) m_mode[z] = M_IDLE;
            else m_age[z]++;
          end
          default: begin
            if (bus.alarm_ack && !f && !s) begin m_mode[z] = M_HOLD; m_age[z] = 0; end
          end
        endcase
        if (m_fs2[z] != m_fdb[z]) begin
          m_frun[z]++;
          if (m_frun[z] == DEBOUNCE) begin m_fdb[z] = m_fs2[z]; m_frun[z] = 0; end
        end else m_frun[z] = 0;
        if (m_ss2[z] != m_sdb[z]) begin
          m_srun[z]++;
          if (m_srun[z] == DEBOUNCE) begin m_sdb[z] = m_ss2[z]; m_srun[z] = 0; end
        end else m_srun[z] = 0;
        m_fs2[z] = m_fs1[z]; m_fs1[z] = bus.fire_det[z];
        m_ss2[z] = m_ss1[z]; m_ss1[z] = bus.smoke_det[z];
        m_ts2[z] = m_ts1[z]; m_ts1[z] = bus.stove_on[z];
      end
      m_alarm = any_spr;
    end
  end

  always @(negedge clk) begin : cmp
    logic [ZONES-1:0] es, ev;
    es = '0;
    ev = '0;
    for (int z = 0; z < ZONES; z++) begin
      es[z] = (m_mode[z] == M_SPR);
      ev[z] = (m_mode[z] != M_IDLE);
    end
    if (cmp_en) begin
      check("model_sprinkler", int'(bus.sprinkler), int'(es));
      check("model_vent", int'(bus.vent), int'(ev));
      check("model_alarm", int'(bus.alarm), int'(m_alarm));
    end
  end

  initial begin : main
    int n;
    bit seen;
    rst_n         = 1'b0;
    bus.stove_on  = '0;
    bus.fire_det  = '0;
    bus.smoke_det = '0;
    bus.alarm_ack = 1'b0;
    repeat (3) tick();
    check("reset_sprinkler", int'(bus.sprinkler), 0);
    check("reset_vent", int'(bus.vent), 0);
    check("reset_alarm", int'(bus.alarm), 0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    repeat (5) tick();

    // Fire latch and acknowledge on zone 0.
    bus.fire_det[0] = 1'b1;
    repeat (6) tick();
    check("fire_edge6_spr", int'(bus.sprinkler[0]), 0);
    tick();
    check("fire_edge7_spr", int'(bus.sprinkler[0]), 1);
    check("fire_edge7_vent", int'(bus.vent[0]), 1);
    check("fire_edge7_alarm", int'(bus.alarm), 0);
    check("fire_zone1_quiet", int'({bus.sprinkler[1], bus.vent[1]}), 0);
    tick();
    check("fire_edge8_alarm", int'(bus.alarm), 1);
    ack_pulse();
    tick();
    check("ack_fire_high", int'(bus.sprinkler[0]), 1);
    bus.fire_det[0] = 1'b0;
    repeat (10) tick();
    check("latched_after_clear", int'(bus.sprinkler[0]), 1);
    ack_pulse();
    check("ack_release_spr", int'(bus.sprinkler[0]), 0);
    check("ack_release_vent", int'(bus.vent[0]), 1);
    measure_vent(0, n);
    check("fire_hold_len", n, VENT_HOLD);

    // Smoke with stove on, zone 1: escalation.
    bus.stove_on[1]  = 1'b1;
    bus.smoke_det[1] = 1'b1;
    repeat (6) tick();
    check("smoke_edge6_vent", int'(bus.vent[1]), 0);
    tick();
    check("smoke_edge7_vent", int'(bus.vent[1]), 1);
    check("smoke_edge7_spr", int'(bus.sprinkler[1]), 0);
    repeat (19) tick();
    check("esc_edge26_spr", int'(bus.sprinkler[1]), 0);
    tick();
    check("esc_edge27_spr", int'(bus.sprinkler[1]), 1);
    bus.smoke_det[1] = 1'b0;
    bus.stove_on[1]  = 1'b0;
    repeat (10) tick();
    ack_pulse();
    repeat (15) tick();
    check("esc_cleanup_vent", int'(bus.vent[1]), 0);

    // Smoke with stove on, cleared before escalation.
    bus.stove_on[1]  = 1'b1;
    bus.smoke_det[1] = 1'b1;
    repeat (15) tick();
    bus.smoke_det[1] = 1'b0;
    repeat (7) tick();
    check("noesc_hold_spr", int'(bus.sprinkler[1]), 0);
    check("noesc_hold_vent", int'(bus.vent[1]), 1);
    measure_vent(1, n);
    check("noesc_hold_len", n, VENT_HOLD);
    check("noesc_never_spr", int'(bus.sprinkler[1]), 0);
    bus.stove_on[1] = 1'b0;
    repeat (5) tick();

    // Smoke with stove off behaves as fire.
    bus.smoke_det[0] = 1'b1;
    repeat (6) tick();
    check("smoke_nostove_e6", int'(bus.sprinkler[0]), 0);
    tick();
    check("smoke_nostove_e7", int'(bus.sprinkler[0]), 1);
    bus.smoke_det[0] = 1'b0;
    repeat (10) tick();
    ack_pulse();
    repeat (15) tick();
    check("smoke_cleanup_vent", int'(bus.vent[0]), 0);

    // Glitch rejection.
    seen = 1'b0;
    for (int w = 1; w <= 3; w++) begin
      bus.fire_det[0] = 1'b1;
      repeat (w) begin tick(); seen |= bus.sprinkler[0] | bus.vent[0]; end
      bus.fire_det[0] = 1'b0;
      repeat (10) begin tick(); seen |= bus.sprinkler[0] | bus.vent[0]; end
    end
    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 0) bus.fire_det[0] = ~bus.fire_det[0];
      tick();
      seen |= bus.sprinkler[0] | bus.vent[0];
    end
    bus.fire_det[0] = 1'b0;
    repeat (10) begin tick(); seen |= bus.sprinkler[0] | bus.vent[0]; end
    check("glitch_rejected", int'(seen), 0);

    // Re-trigger during hold, ack coinciding with the debounced fire rise.
    bus.fire_det[0] = 1'b1;
    repeat (7) tick();
    check("retrig_first_spr", int'(bus.sprinkler[0]), 1);
    bus.fire_det[0] = 1'b0;
    repeat (10) tick();
    ack_pulse();
    check("retrig_in_hold", int'({bus.sprinkler[0], bus.vent[0]}), 1);
    bus.fire_det[0] = 1'b1;
    repeat (6) tick();
    check("retrig_e6_hold", int'({bus.sprinkler[0], bus.vent[0]}), 1);
    ack_pulse();
    check("retrig_e7_spr", int'(bus.sprinkler[0]), 1);
    repeat (2) tick();
    check("retrig_ack_ignored", int'(bus.sprinkler[0]), 1);
    check("retrig_alarm", int'(bus.alarm), 1);

    // Asynchronous reset while sprinkling.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_spr", int'(bus.sprinkler), 0);
    check("async_rst_vent", int'(bus.vent), 0);
    check("async_rst_alarm", int'(bus.alarm), 0);
    bus.fire_det = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (100) begin
      tick();
      seen |= (|bus.sprinkler) | (|bus.vent) | bus.alarm;
    end
    check("idle_after_reset", int'(seen), 0);

    // Randomized traffic, with one asynchronous reset pulse midway.
    for (int c = 0; c < 3000; c++) begin
      for (int z = 0; z < ZONES; z++) begin
        if ($urandom_range(11) == 0) bus.fire_det[z]  = ~bus.fire_det[z];
        if ($urandom_range(19) == 0) bus.smoke_det[z] = ~bus.smoke_det[z];
        if ($urandom_range(29) == 0) bus.stove_on[z]  = ~bus.stove_on[z];
      end
      bus.alarm_ack = ($urandom_range(7) == 0);
      tick();
      if (c == 1500) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
    end
    bus.fire_det  = '0;
    bus.smoke_det = '0;
    bus.stove_on  = '0;
    bus.alarm_ack = 1'b0;
    repeat (30) tick();

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
